// File: rtl/decoder_nxm_pipe.sv
// Registered binary-to-line decoder (one-hot or thermometer) with out-of-range flag and saturating error counter.
// Latency: 1 cycle from accept (in_valid & in_ready) to out_valid.
// Backpressure: single output register; in_ready = en & (~out_valid | out_ready), so it holds while out_ready is low.
module decoder_nxm_pipe #(
   parameter int IN_W  = 3,
   parameter int OUT_W = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             mode,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_code,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_err,
   input  logic             err_clr,
   output logic [CNT_W-1:0] err_count
);

   // Counter saturation value and unit increment, sized to the counter.
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic             w_in_ready;
   logic             w_accept;
   logic             w_in_range;
   logic [OUT_W-1:0] w_dec;
   logic [CNT_W-1:0] w_cnt_base;
   logic [CNT_W-1:0] w_cnt_next;

   logic             r_out_valid;
   logic [OUT_W-1:0] r_out_data;
   logic             r_out_err;
   logic [CNT_W-1:0] r_err_count;

   // The slot is free when empty or when its content leaves this cycle.
   assign w_in_ready = en & (~r_out_valid | out_ready);
   assign w_accept   = in_valid & w_in_ready;

   // When every code maps to a line, the range check collapses to a constant
   // so out_err can never be set.
   generate
      if (OUT_W >= (2 ** IN_W)) begin : g_full_range
         assign w_in_range = 1'b1;
      end else begin : g_partial_range
         localparam logic [IN_W:0] OUT_W_C = (IN_W + 1)'(OUT_W);
         assign w_in_range = ({1'b0, in_code} < OUT_W_C);
      end
   endgenerate

   // Decode the incoming code into one-hot or thermometer lines; all zero if out of range.
   always_comb begin
      w_dec = '0;
      for (int k = 0; k < OUT_W; k++) begin
         if (mode) begin
            w_dec[k] = w_in_range && (k <= int'(in_code));
         end else begin
            w_dec[k] = w_in_range && (k == int'(in_code));
         end
      end
   end

   // Clear takes effect before the increment, so clear plus an erroring accept yields one.
   always_comb begin
      w_cnt_base = err_clr ? '0 : r_err_count;
      w_cnt_next = w_cnt_base;
      if (w_accept && !w_in_range && (w_cnt_base != CNT_MAX)) begin
         w_cnt_next = w_cnt_base + CNT_ONE;
      end
   end

   // Output register: load on accept, drop valid on a drain with no refill.
   // Data and error flag keep their last value when valid falls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_err   <= 1'b0;
      end else if (w_accept) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_dec;
         r_out_err   <= ~w_in_range;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   // Saturating count of accepted out-of-range codes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_count <= '0;
      end else begin
         r_err_count <= w_cnt_next;
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_err   = r_out_err;
   assign err_count = r_err_count;

endmodule

// File: tb/tb_decoder_nxm_pipe.sv
// Bench for decoder_nxm_pipe: three instances share inputs
// (a: 3/8/8 full range, b: 3/6/8 partial range, c: 3/6/2 small counter).
module tb_decoder_nxm_pipe;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       mode;
   logic       in_valid;
   logic [2:0] in_code;
   logic       out_ready;
   logic       err_clr;

   logic       in_ready_a, out_valid_a, out_err_a;
   logic [7:0] out_data_a, err_count_a;
   logic       in_ready_b, out_valid_b, out_err_b;
   logic [5:0] out_data_b;
   logic [7:0] err_count_b;
   logic       in_ready_c, out_valid_c, out_err_c;
   logic [5:0] out_data_c;
   logic [1:0] err_count_c;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   decoder_nxm_pipe #(.IN_W(3), .OUT_W(8), .CNT_W(8)) u_a (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
      .in_ready(in_ready_a), .in_code(in_code), .out_valid(out_valid_a),
      .out_ready(out_ready), .out_data(out_data_a), .out_err(out_err_a),
      .err_clr(err_clr), .err_count(err_count_a));

   decoder_nxm_pipe #(.IN_W(3), .OUT_W(6), .CNT_W(8)) u_b (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
      .in_ready(in_ready_b), .in_code(in_code), .out_valid(out_valid_b),
      .out_ready(out_ready), .out_data(out_data_b), .out_err(out_err_b),
      .err_clr(err_clr), .err_count(err_count_b));

   decoder_nxm_pipe #(.IN_W(3), .OUT_W(6), .CNT_W(2)) u_c (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
      .in_ready(in_ready_c), .in_code(in_code), .out_valid(out_valid_c),
      .out_ready(out_ready), .out_data(out_data_c), .out_err(out_err_c),
      .err_clr(err_clr), .err_count(err_count_c));

   // Per-instance views for the randomized loop.
   logic [31:0] o_rdy [3];
   logic [31:0] o_vld [3];
   logic [31:0] o_dat [3];
   logic [31:0] o_err [3];
   logic [31:0] o_cnt [3];
   assign o_rdy[0] = 32'(in_ready_a);  assign o_rdy[1] = 32'(in_ready_b);  assign o_rdy[2] = 32'(in_ready_c);
   assign o_vld[0] = 32'(out_valid_a); assign o_vld[1] = 32'(out_valid_b); assign o_vld[2] = 32'(out_valid_c);
   assign o_dat[0] = 32'(out_data_a);  assign o_dat[1] = 32'(out_data_b);  assign o_dat[2] = 32'(out_data_c);
   assign o_err[0] = 32'(out_err_a);   assign o_err[1] = 32'(out_err_b);   assign o_err[2] = 32'(out_err_c);
   assign o_cnt[0] = 32'(err_count_a); assign o_cnt[1] = 32'(err_count_b); assign o_cnt[2] = 32'(err_count_c);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected lines for a code: one-hot is a single set bit, thermometer is a
   // run of ones ending at the code; nothing is set when the code has no line.
   function automatic logic [31:0] ref_lines(input int code, input bit md, input int ow);
      if (code >= ow) return 32'd0;
      if (md) return (32'd1 << (code + 1)) - 32'd1;
      return 32'd1 << code;
   endfunction

   int          ow_tab   [3] = '{8, 6, 6};
   int          cmax_tab [3] = '{255, 255, 3};
   logic [32:0] mq [3][$];      // {err, data} awaiting consumption
   int          mcnt [3];

   initial begin
      int t2_code [3] = '{0, 3, 7};
      int t2_exp  [3] = '{32'h01, 32'h0F, 32'hFF};
      int t5_exp  [5] = '{1, 2, 3, 3, 3};

      rst_n = 1'b0; en = 1'b0; mode = 1'b0; in_valid = 1'b0;
      in_code = 3'd0; out_ready = 1'b0; err_clr = 1'b0;
      #3;
      chk("rst_out_valid", 32'(out_valid_a), 32'd0);
      chk("rst_out_data",  32'(out_data_a),  32'd0);
      chk("rst_out_err",   32'(out_err_b),   32'd0);
      chk("rst_err_count", 32'(err_count_b), 32'd0);
      tick();
      rst_n = 1'b1;

      // T1: one-hot stream 0..7 back-to-back.
      en = 1'b1; out_ready = 1'b1; mode = 1'b0; in_valid = 1'b1; in_code = 3'd0;
      #1;
      chk("t1_in_ready", 32'(in_ready_a), 32'd1);
      chk("t1_pre_valid", 32'(out_valid_a), 32'd0);
      for (int i = 0; i < 8; i++) begin
         in_code = 3'(i);
         tick();
         chk("t1_valid", 32'(out_valid_a), 32'd1);
         chk("t1_data",  32'(out_data_a),  32'd1 << i);
         chk("t1_err",   32'(out_err_a),   32'd0);
      end
      in_valid = 1'b0;
      tick();
      chk("t1_drain_valid", 32'(out_valid_a), 32'd0);
      chk("t1_drain_keep",  32'(out_data_a),  32'h80);

      // T2: thermometer.
      mode = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_code = 3'(t2_code[i]);
         tick();
         chk("t2_data", 32'(out_data_a), 32'(t2_exp[i]));
      end
      in_valid = 1'b0;
      tick();

      // T3: out-of-range codes on the 6-line instance.
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("t3_cnt_clr", 32'(err_count_b), 32'd0);
      mode = 1'b0; in_valid = 1'b1; in_code = 3'd6;
      tick();
      chk("t3_c6_data", 32'(out_data_b), 32'd0);
      chk("t3_c6_err",  32'(out_err_b),  32'd1);
      chk("t3_c6_full", 32'(out_data_a), 32'h40);
      chk("t3_c6_ferr", 32'(out_err_a),  32'd0);
      in_code = 3'd7;
      tick();
      chk("t3_c7_data", 32'(out_data_b), 32'd0);
      chk("t3_c7_err",  32'(out_err_b),  32'd1);
      chk("t3_cnt2",    32'(err_count_b), 32'd2);
      mode = 1'b1; in_code = 3'd5;
      tick();
      chk("t3_c5_data", 32'(out_data_b), 32'h3F);
      chk("t3_c5_err",  32'(out_err_b),  32'd0);
      chk("t3_cnt_hold", 32'(err_count_b), 32'd2);
      in_valid = 1'b0;
      tick();

      // T4: backpressure.
      mode = 1'b0; in_valid = 1'b1; in_code = 3'd2; out_ready = 1'b0;
      tick();
      chk("t4_first", 32'(out_data_a), 32'h04);
      in_code = 3'd5;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t4_hold_rdy",   32'(in_ready_a),  32'd0);
         chk("t4_hold_valid", 32'(out_valid_a), 32'd1);
         chk("t4_hold_data",  32'(out_data_a),  32'h04);
         tick();
      end
      out_ready = 1'b1;
      #1;
      chk("t4_release_rdy", 32'(in_ready_a), 32'd1);
      chk("t4_consume",     32'(out_data_a), 32'h04);
      tick();
      chk("t4_next_valid", 32'(out_valid_a), 32'd1);
      chk("t4_next_data",  32'(out_data_a),  32'h20);
      in_valid = 1'b0;
      tick();
      chk("t4_drained", 32'(out_valid_a), 32'd0);

      // T5: 2-bit counter saturation and clear priority.
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0; in_valid = 1'b1; in_code = 3'd7;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t5_sat", 32'(err_count_c), 32'(t5_exp[i]));
      end
      err_clr = 1'b1;
      tick();
      chk("t5_clr_inc", 32'(err_count_c), 32'd1);
      in_valid = 1'b0;
      tick();
      chk("t5_clr_only", 32'(err_count_c), 32'd0);
      err_clr = 1'b0;

      // T6: asynchronous reset mid-stream, then en=0 blocks acceptance.
      in_valid = 1'b1; in_code = 3'd7;
      tick();
      tick();
      chk("t6_pre_valid", 32'(out_valid_b), 32'd1);
      chk("t6_pre_cnt",   32'(err_count_b), 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", 32'(out_valid_a), 32'd0);
      chk("t6_rst_data",  32'(out_data_a),  32'd0);
      chk("t6_rst_err",   32'(out_err_b),   32'd0);
      chk("t6_rst_cnt",   32'(err_count_b), 32'd0);
      en = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      chk("t6_en0_rdy", 32'(in_ready_a), 32'd0);
      tick();
      tick();
      chk("t6_en0_valid", 32'(out_valid_a), 32'd0);
      chk("t6_en0_cnt",   32'(err_count_b), 32'd0);

      // Randomized run against the queue-based reference model.
      for (int i = 0; i < 3; i++) begin
         mq[i].delete();
         mcnt[i] = 0;
      end
      for (int cyc = 0; cyc < 1000; cyc++) begin
         en        = ($urandom_range(9, 0) != 0);
         in_valid  = ($urandom_range(3, 0) != 0);
         out_ready = ($urandom_range(2, 0) != 0);
         mode      = 1'($urandom_range(1, 0));
         in_code   = 3'($urandom_range(7, 0));
         err_clr   = ($urandom_range(29, 0) == 0);
         #1;
         for (int i = 0; i < 3; i++) begin
            bit          room;
            bit          acc;
            logic [32:0] head;
            room = (mq[i].size() == 0) || out_ready;
            acc  = in_valid && en && room;
            chk("rnd_in_ready",  o_rdy[i], 32'(en && room));
            chk("rnd_out_valid", o_vld[i], 32'(mq[i].size() != 0));
            chk("rnd_err_count", o_cnt[i], 32'(mcnt[i]));
            if (mq[i].size() != 0) begin
               head = mq[i][0];
               chk("rnd_out_data", o_dat[i], head[31:0]);
               chk("rnd_out_err",  o_err[i], 32'(head[32]));
               if (out_ready) void'(mq[i].pop_front());
            end
            if (acc) begin
               mq[i].push_back({(int'(in_code) >= ow_tab[i]),
                                ref_lines(int'(in_code), mode, ow_tab[i])});
            end
            if (err_clr) mcnt[i] = 0;
            if (acc && (int'(in_code) >= ow_tab[i]) && (mcnt[i] < cmax_tab[i])) mcnt[i]++;
         end
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
